// File: rtl/mem_access_ctrl.sv
// Bus initiator between the CPU pipeline and the MMU: arbitrates fetch vs data
// requests and sequences SRAM-safe read/write strobes with a ready pulse per access.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_inst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_byte,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        mmu_read,
    output logic        mmu_write,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    output logic        mmu_bytemode,
    input  logic [31:0] mmu_rdata
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR, WR_HOLD, DONE} state_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        port_q, port_d;        // 1 = data port, 0 = fetch port
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        byte_q, byte_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [7:0]  rd_lane;
    logic [31:0] rd_fmt;

    always_comb begin
        rd_lane = mmu_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_fmt  = byte_q ? {{24{rd_lane[7]}}, rd_lane} : mmu_rdata;
    end

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte_d      = byte_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem_wr || mem_rd) begin
                    port_d  = 1'b1;
                    addr_d  = mem_addr;
                    byte_d  = mem_byte;
                    wdata_d = mem_byte ? {4{mem_wdata[7:0]}} : mem_wdata;
                    cnt_d   = '0;
                    state_d = mem_wr ? WR_SETUP : RD;
                end else if (if_req) begin
                    port_d  = 1'b0;
                    addr_d  = if_addr;
                    byte_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    if (port_q) mem_rdata_d = rd_fmt;
                    else        if_inst_d   = mmu_rdata;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR;
            end
            WR: begin
                if (cnt_q == LAST_CNT) state_d = WR_HOLD;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_q      <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_q      <= byte_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Strobes decode straight from state, so they can never overlap or leak into IDLE/DONE.
    assign mmu_read     = (state_q == RD);
    assign mmu_write    = (state_q == WR);
    assign mmu_addr     = addr_q;
    assign mmu_wdata    = wdata_q;
    assign mmu_bytemode = byte_q;

    assign if_ready  = (state_q == DONE) && !port_q;
    assign mem_ready = (state_q == DONE) &&  port_q;
    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;

    assign stall = (if_req & ~if_ready) | ((mem_rd | mem_wr) & ~mem_ready);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl (WAIT_CYCLES = 2); expected cycle
// timing and data values are hand-derived from the access sequencing rules.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        mmu_read;
    logic        mmu_write;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_wdata;
    logic        mmu_bytemode;
    logic [31:0] mmu_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ready     (if_ready),
        .if_inst      (if_inst),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_byte     (mem_byte),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .mmu_read     (mmu_read),
        .mmu_write    (mmu_write),
        .mmu_addr     (mmu_addr),
        .mmu_wdata    (mmu_wdata),
        .mmu_bytemode (mmu_bytemode),
        .mmu_rdata    (mmu_rdata)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_byte = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; mmu_rdata = '0;
        tick();
        tick();
        n_checks++;
        if ({mmu_read, mmu_write, mmu_bytemode, if_ready, mem_ready, stall} !== 6'b0 ||
            mmu_addr !== 32'h0 || mmu_wdata !== 32'h0 || if_inst !== 32'h0 || mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: rd=%b wr=%b bm=%b ifr=%b mr=%b stall=%b addr=%h wdata=%h inst=%h rdata=%h, expected all zero",
                     mmu_read, mmu_write, mmu_bytemode, if_ready, mem_ready, stall, mmu_addr, mmu_wdata, if_inst, mem_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch(input logic [31:0] addr, input logic [31:0] data);
        logic exp_rd;
        if_addr = addr; mmu_rdata = data; if_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp_rd = (c <= 2);
            n_checks++;
            if (mmu_read !== exp_rd || mmu_write !== 1'b0 || (exp_rd && mmu_addr !== addr)) begin
                n_fail++;
                $display("FAIL fetch_strobe c=%0d: read=%b write=%b addr=%h, expected read=%b write=0 addr=%h",
                         c, mmu_read, mmu_write, mmu_addr, exp_rd, addr);
            end
            n_checks++;
            if (if_ready !== (c == 3) || mem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_ready c=%0d: if_ready=%b mem_ready=%b, expected if_ready=%b mem_ready=0",
                         c, if_ready, mem_ready, (c == 3));
            end
            if (c == 3) begin
                n_checks++;
                if (if_inst !== data) begin
                    n_fail++;
                    $display("FAIL fetch_data: if_inst=%h, expected %h", if_inst, data);
                end
                if_req = 1'b0;
            end
            #1;
            n_checks++;
            if (stall !== (c < 3)) begin
                n_fail++;
                $display("FAIL fetch_stall c=%0d: stall=%b, expected %b", c, stall, (c < 3));
            end
        end
    endtask

    task automatic test_word_write();
        logic exp_wr;
        mem_addr = 32'h8000_0100; mem_wdata = 32'hDEAD_BEEF; mem_byte = 1'b0; mem_wr = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp_wr = (c == 2 || c == 3);
            n_checks++;
            if (mmu_write !== exp_wr || mmu_read !== 1'b0) begin
                n_fail++;
                $display("FAIL wwrite_strobe c=%0d: write=%b read=%b, expected write=%b read=0",
                         c, mmu_write, mmu_read, exp_wr);
            end
            if (c <= 4) begin
                n_checks++;
                if (mmu_addr !== 32'h8000_0100 || mmu_wdata !== 32'hDEAD_BEEF || mmu_bytemode !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wwrite_bus c=%0d: addr=%h wdata=%h bm=%b, expected 80000100 deadbeef 0",
                             c, mmu_addr, mmu_wdata, mmu_bytemode);
                end
            end
            n_checks++;
            if (mem_ready !== (c == 5) || if_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wwrite_ready c=%0d: mem_ready=%b if_ready=%b, expected mem_ready=%b if_ready=0",
                         c, mem_ready, if_ready, (c == 5));
            end
            if (c == 5) mem_wr = 1'b0;
            #1;
            n_checks++;
            if (stall !== (c < 5)) begin
                n_fail++;
                $display("FAIL wwrite_stall c=%0d: stall=%b, expected %b", c, stall, (c < 5));
            end
        end
    endtask

    task automatic test_byte_read();
        logic [31:0] addrs [2];
        logic [31:0] exps  [2];
        addrs[0] = 32'h0000_1003; exps[0] = 32'hFFFF_FF80;
        addrs[1] = 32'h0000_1001; exps[1] = 32'h0000_0022;
        mmu_rdata = 32'h8011_2233;
        for (int i = 0; i < 2; i++) begin
            mem_addr = addrs[i]; mem_byte = 1'b1; mem_rd = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (c <= 2) begin
                    n_checks++;
                    if (mmu_read !== 1'b1 || mmu_bytemode !== 1'b1 || mmu_addr !== addrs[i]) begin
                        n_fail++;
                        $display("FAIL bread_bus i=%0d c=%0d: read=%b bm=%b addr=%h, expected 1 1 %h",
                                 i, c, mmu_read, mmu_bytemode, mmu_addr, addrs[i]);
                    end
                end
                n_checks++;
                if (mem_ready !== (c == 3)) begin
                    n_fail++;
                    $display("FAIL bread_ready i=%0d c=%0d: mem_ready=%b, expected %b", i, c, mem_ready, (c == 3));
                end
                if (c == 3) begin
                    n_checks++;
                    if (mem_rdata !== exps[i]) begin
                        n_fail++;
                        $display("FAIL bread_data i=%0d: mem_rdata=%h, expected %h", i, mem_rdata, exps[i]);
                    end
                    mem_rd = 1'b0;
                end
            end
        end
        mem_byte = 1'b0;
    endtask

    task automatic test_byte_write();
        mem_addr = 32'h0000_2002; mem_wdata = 32'h0000_00A5; mem_byte = 1'b1; mem_wr = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) begin
                n_checks++;
                if (mmu_wdata !== 32'hA5A5_A5A5 || mmu_bytemode !== 1'b1 || mmu_addr !== 32'h0000_2002) begin
                    n_fail++;
                    $display("FAIL bwrite_bus c=%0d: wdata=%h bm=%b addr=%h, expected a5a5a5a5 1 00002002",
                             c, mmu_wdata, mmu_bytemode, mmu_addr);
                end
            end
            n_checks++;
            if (mmu_write !== (c == 2 || c == 3) || mem_ready !== (c == 5)) begin
                n_fail++;
                $display("FAIL bwrite_seq c=%0d: write=%b mem_ready=%b, expected write=%b mem_ready=%b",
                         c, mmu_write, mem_ready, (c == 2 || c == 3), (c == 5));
            end
            if (c == 5) begin
                mem_wr = 1'b0; mem_byte = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rd;
        logic [31:0] exp_addr;
        if_addr = 32'h0000_0020; if_req = 1'b1;
        mem_addr = 32'h0000_0100; mem_byte = 1'b0; mem_rd = 1'b1;
        mmu_rdata = 32'h1111_1111;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp_rd   = (c == 1 || c == 2 || c == 5 || c == 6);
            exp_addr = (c <= 2) ? 32'h0000_0100 : 32'h0000_0020;
            n_checks++;
            if (mmu_read !== exp_rd || mmu_write !== 1'b0 || (exp_rd && mmu_addr !== exp_addr)) begin
                n_fail++;
                $display("FAIL b2b_strobe c=%0d: read=%b write=%b addr=%h, expected read=%b write=0 addr=%h",
                         c, mmu_read, mmu_write, mmu_addr, exp_rd, exp_addr);
            end
            n_checks++;
            if (mem_ready !== (c == 3) || if_ready !== (c == 7)) begin
                n_fail++;
                $display("FAIL b2b_ready c=%0d: mem_ready=%b if_ready=%b, expected %b %b",
                         c, mem_ready, if_ready, (c == 3), (c == 7));
            end
            if (c == 3) begin
                n_checks++;
                if (mem_rdata !== 32'h1111_1111) begin
                    n_fail++;
                    $display("FAIL b2b_mem_data: mem_rdata=%h, expected 11111111", mem_rdata);
                end
                mem_rd = 1'b0;
                mmu_rdata = 32'hCAFE_F00D;
            end
            if (c == 7) begin
                n_checks++;
                if (if_inst !== 32'hCAFE_F00D || mem_rdata !== 32'h1111_1111) begin
                    n_fail++;
                    $display("FAIL b2b_if_data: if_inst=%h mem_rdata=%h, expected cafef00d 11111111", if_inst, mem_rdata);
                end
                if_req = 1'b0;
            end
            #1;
            n_checks++;
            if (stall !== (c < 7)) begin
                n_fail++;
                $display("FAIL b2b_stall c=%0d: stall=%b, expected %b", c, stall, (c < 7));
            end
        end
    endtask

    task automatic test_reset_mid_access();
        if_addr = 32'h0000_0040; mmu_rdata = 32'h1234_5678; if_req = 1'b1;
        tick();
        tick();
        n_checks++;
        if (mmu_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: mmu_read=%b in second RD cycle, expected 1", mmu_read);
        end
        rst_n = 1'b0; if_req = 1'b0;
        tick();
        n_checks++;
        if (mmu_read !== 1'b0 || if_ready !== 1'b0 || mmu_addr !== 32'h0 || if_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_abort: read=%b if_ready=%b addr=%h inst=%h, expected 0 0 00000000 00000000",
                     mmu_read, if_ready, mmu_addr, if_inst);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++;
            if (if_ready !== 1'b0 || mem_ready !== 1'b0 || mmu_read !== 1'b0 || mmu_write !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_idle c=%0d: if_ready=%b mem_ready=%b read=%b write=%b, expected all 0",
                         c, if_ready, mem_ready, mmu_read, mmu_write);
            end
        end
        test_fetch(32'h0000_0044, 32'h0BAD_CAFE);
    endtask

    initial begin
        test_reset();
        test_fetch(32'h0000_0008, 32'h3002_000C);
        test_word_write();
        test_byte_read();
        test_byte_write();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
